// File: rtl/ex_muldiv_if.sv
// Pipeline-facing port bundle of the EX-stage multiply/divide unit.
// Handshake: an op is taken on a rising edge where issue_valid=1, flush=0 and the
// unit is idle; stall=1 means "not taken, re-present next cycle"; result is only
// meaningful in a cycle where result_valid=1.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            issue_valid;
  logic [3:0]      md_op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            flush;
  logic            stall;
  logic            busy;
  logic [XLEN-1:0] result;
  logic            result_valid;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output issue_valid, md_op, A, B, flush,
    input  stall, busy, result, result_valid, hi, lo
  );

  modport slave (
    input  issue_valid, md_op, A, B, flush,
    output stall, busy, result, result_valid, hi, lo
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiply with
// MUL_STEP_BITS bits per cycle, restoring divide at one quotient bit per cycle.
module ex_muldiv #(
  parameter int XLEN          = 32,
  parameter int MUL_STEP_BITS = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  ex_muldiv_if.slave md,
  output logic [1:0] dbg_state
);

  if (XLEN < 8 || (XLEN % 2) != 0 ||
      !(MUL_STEP_BITS == 1 || MUL_STEP_BITS == 2 || MUL_STEP_BITS == 4) ||
      (XLEN % MUL_STEP_BITS) != 0) begin : g_bad_params
    $error("ex_muldiv: illegal XLEN/MUL_STEP_BITS combination");
  end

  localparam int N  = XLEN / MUL_STEP_BITS;
  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t            state;
  logic              busy_r;
  logic [XLEN-1:0]   hi_r, lo_r;
  logic [2*XLEN-1:0] opa;      // multiplicand (shifted left) / dividend->quotient in low half
  logic [XLEN-1:0]   opb;      // multiplier (shifted right) / divisor
  logic [2*XLEN-1:0] acc;      // product / remainder in low half
  logic [CW-1:0]     cnt;
  logic              a_neg_r, b_neg_r, is_div;

  logic              accept, op_signed, a_neg, b_neg, is_mf;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [2*XLEN-1:0] mul_sum;
  logic [XLEN:0]     div_trial;
  logic              q_bit;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  assign accept    = (state == S_IDLE) && md.issue_valid && !md.flush;
  assign op_signed = (md.md_op == OP_MULT) || (md.md_op == OP_DIV);
  assign a_neg     = op_signed && md.A[XLEN-1];
  assign b_neg     = op_signed && md.B[XLEN-1];
  // MIN negates to itself, which is exactly the right unsigned magnitude.
  assign abs_a     = a_neg ? (~md.A + 1'b1) : md.A;
  assign abs_b     = b_neg ? (~md.B + 1'b1) : md.B;
  assign is_mf     = (md.md_op == OP_MFHI) || (md.md_op == OP_MFLO);

  always_comb begin
    mul_sum = acc;
    for (int i = 0; i < MUL_STEP_BITS; i++) begin
      if (opb[i]) mul_sum = mul_sum + (opa << i);
    end
  end

  assign div_trial = {acc[XLEN-1:0], opa[XLEN-1]} - {1'b0, opb};
  assign q_bit     = !div_trial[XLEN];

  assign prod_fix = (a_neg_r ^ b_neg_r) ? (~acc + 1'b1) : acc;
  assign quot_fix = (opb == '0) ? '1 :
                    (a_neg_r ^ b_neg_r) ? (~opa[XLEN-1:0] + 1'b1) : opa[XLEN-1:0];
  assign rem_fix  = a_neg_r ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      busy_r  <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      cnt     <= '0;
      a_neg_r <= 1'b0;
      b_neg_r <= 1'b0;
      is_div  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (md.md_op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                opa     <= {{XLEN{1'b0}}, abs_a};
                opb     <= abs_b;
                acc     <= '0;
                cnt     <= '0;
                a_neg_r <= a_neg;
                b_neg_r <= b_neg;
                is_div  <= (md.md_op == OP_DIV) || (md.md_op == OP_DIVU);
                busy_r  <= 1'b1;
                state   <= ((md.md_op == OP_DIV) || (md.md_op == OP_DIVU)) ? S_DIV : S_MUL;
              end
              OP_MTHI: hi_r <= md.A;
              OP_MTLO: lo_r <= md.A;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (md.flush) begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
          end else begin
            acc <= mul_sum;
            opa <= opa << MUL_STEP_BITS;
            opb <= opb >> MUL_STEP_BITS;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(N - 1)) state <= S_FIX;
          end
        end
        S_DIV: begin
          if (md.flush) begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
          end else begin
            acc <= {{XLEN{1'b0}}, q_bit ? div_trial[XLEN-1:0] : {acc[XLEN-2:0], opa[XLEN-1]}};
            opa <= {{XLEN{1'b0}}, opa[XLEN-2:0], q_bit};
            cnt <= cnt + 1'b1;
            if (cnt == CW'(XLEN - 1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
          if (!md.flush) begin
            if (is_div) begin
              hi_r <= rem_fix;
              lo_r <= quot_fix;
            end else begin
              {hi_r, lo_r} <= prod_fix;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign md.busy         = busy_r;
  assign md.stall        = busy_r && md.issue_valid && (md.md_op >= OP_MULT) && (md.md_op <= OP_MFLO);
  assign md.result_valid = (state == S_IDLE) && md.issue_valid && !md.flush && is_mf;
  assign md.result       = !md.result_valid ? '0 : (md.md_op == OP_MFHI) ? hi_r : lo_r;
  assign md.hi           = hi_r;
  assign md.lo           = lo_r;
  assign dbg_state       = state;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Iterative multiply/divide execution unit beside the EX-stage ALU.
- Parametrised in data width and multiplier radix.
- Owns the HI/LO register pair.
- Supports MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- Stalls the pipeline while an operation is in flight.
- Operands arrive already forwarded, so the block sees final A/B values.

Parameters:
XLEN, 32, operand/HI/LO width; must be even, ≥8.
MUL_STEP_BITS, 1, multiplier bits retired per cycle; legal values 1, 2, 4; must divide XLEN.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
issue_valid  input  1  EX holds a muldiv instruction this cycle.
md_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9–15 treated as NONE.
A  input  XLEN  rs operand (dividend / multiplicand / MT source).
B  input  XLEN  rt operand (divisor / multiplier).
flush  input  1  kill in-flight operation and ignore this cycle's issue.
stall  output  1  hold EX and earlier stages this cycle.
busy  output  1  iterative operation in progress.
result  output  XLEN  MFHI/MFLO read data.
result_valid  output  1  result is meaningful this cycle.
hi  output  XLEN  architectural HI.
lo  output  XLEN  architectural LO.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; hi=0; lo=0; busy=0; stall=0; result_valid=0; result=0.
  - Internal counters and accumulators are cleared.
- State machine IDLE -> MUL | DIV -> FIX -> IDLE.
- Accept rule: an op is accepted on an edge where state=IDLE, issue_valid=1, flush=0.
- IDLE, op MULT/MULTU/DIV/DIVU accepted:
  - Latch operand magnitudes: absolute values for signed ops, raw for unsigned.
  - Latch sign flags.
  - cnt=0; go to MUL or DIV.
- IDLE, MTHI/MTLO accepted: hi (or lo) <= A at that edge; stay IDLE; no stall.
- MFHI/MFLO in IDLE, combinational:
  - result = hi or lo; result_valid=1.
  - An MT on the same edge updates the register after the read, so MF returns the old value.
- MUL state:
  - Shift-add, MUL_STEP_BITS multiplier bits per cycle.
  - Runs N=XLEN/MUL_STEP_BITS cycles, then goes to FIX.
  - Product width is 2*XLEN.
- DIV state:
  - Restoring division, 1 quotient bit per cycle.
  - Runs XLEN cycles, then goes to FIX.
- FIX state (1 cycle):
  - Signed multiply: negate the 2*XLEN product if the sign flags differ.
  - Signed divide: negate the quotient if the sign flags differ; the remainder takes the dividend's sign.
  - {hi,lo} <= product, or hi<=remainder, lo<=quotient, at the FIX exit edge; return to IDLE.
- Latency from accept edge E0:
  - hi/lo valid after edge E0+N+1 (MUL) or E0+XLEN+1 (DIV).
  - Defaults: 33 cycles for MULT, 33 cycles for DIV.
- busy=1 from the edge after E0 through the FIX cycle inclusive; busy is registered.
- stall = busy & issue_valid & (md_op in 1..8), combinational.
  - The stalled op is re-presented by the pipeline and accepted in the first IDLE cycle.
  - MFHI/MFLO while busy stall; they never return stale data.
  - result_valid=0 while stalled.
- Non-muldiv traffic (md_op NONE) never stalls, even while busy.
- Divide by zero (B=0), signed or unsigned: hi=A, lo=all ones. No exception; same latency.
- Signed overflow, MIN/-1: lo=MIN, hi=0.
- Signed MIN operands: magnitude 2^(XLEN-1) must be handled without loss. Use XLEN-bit unsigned magnitudes.
- flush:
  - When busy, flush=1 aborts to IDLE at the next edge; hi/lo unchanged; busy drops that edge.
  - When flush=1 in IDLE, no issue is accepted and MT writes are suppressed.
  - result_valid is forced 0 during flush.
- Reset mid-operation: immediate abort; hi/lo cleared to 0.
- Illegal parameter values are rejected at elaboration.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE lo=0x00000001; busy high 33 cycles; stall only while an MD op is presented.
- MULT A=0xFFFFFFFD(-3) B=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; repeat with MUL_STEP_BITS=4 -> same values after 9 cycles.
- DIV A=-7 B=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIVU A=100 B=7 -> lo=14 hi=2; DIV A=0x80000000 B=0xFFFFFFFF -> lo=0x80000000 hi=0.
- Divide by zero: DIVU A=0x1234 B=0 -> hi=0x1234 lo=0xFFFFFFFF after 33 cycles.
- MFLO issued 1 cycle after DIVU accept -> stall=1 for 33 cycles, then result=quotient with result_valid=1; MTHI 0xAA in IDLE with same-cycle MFHI -> result=old hi, hi=0xAA next cycle.
- Flush at cycle 10 of a MULT -> busy drops next edge, hi/lo retain prior values; reset_n pulse mid-DIV -> hi=lo=0, state IDLE immediately.
